membus_arbiter: RTL and testbench
=================================

Name: membus_arbiter

Overview:
- Shares the single MMIO request port between the core's instruction-fetch bus (read-only, ILEN data) and data bus (read/write, DATA_WIDTH data).
- Data requests win by default. A starvation counter forces a fetch grant after STARVE_LIMIT consecutive data grants made while a fetch was waiting.
- Every issued request is tagged in an in-order FIFO. Each response is routed back to the requester that issued it, and fetch data is lane-selected by address bit 2.
- Sits between the core's i/d buses and mmio_controller, and replaces the inline combinational arbitration in the core top.

Parameters:
- XLEN, 64, address width
- ILEN, 32, fetch data width
- DATA_WIDTH, 64, MMIO/data-bus data width; must equal 2*ILEN
- MAX_OUTSTANDING, 2, tag FIFO depth (number of in-flight requests); power of two, ≥1
- STARVE_LIMIT, 4, consecutive data grants with a fetch waiting before the fetch is forced; range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  fetch request
- i_ready  out  1  fetch request accepted
- i_addr  in  XLEN  fetch byte address
- i_rvalid  out  1  fetch response valid
- i_rdata  out  ILEN  fetch response data
- d_valid  in  1  data request
- d_ready  out  1  data request accepted
- d_addr  in  XLEN  data byte address
- d_wen  in  1  write enable
- d_wdata  in  DATA_WIDTH  write data
- d_wmask  in  DATA_WIDTH/8  byte write mask
- d_rvalid  out  1  data response valid
- d_rdata  out  DATA_WIDTH  data response data
- m_valid  out  1  MMIO request
- m_ready  in  1  MMIO accepts request
- m_addr  out  XLEN  MMIO address
- m_wen  out  1  MMIO write enable
- m_wdata  out  DATA_WIDTH  MMIO write data
- m_wmask  out  DATA_WIDTH/8  MMIO byte mask
- m_rvalid  in  1  MMIO response valid
- m_rdata  in  DATA_WIDTH  MMIO response data
- busy  out  1  tag FIFO non-empty
- resp_err  out  1  sticky flag: an m_rvalid arrived with the FIFO empty

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset: FIFO empty (wr_ptr = rd_ptr = count = 0), starve counter 0, resp_err 0. All outputs derive from this state: busy=0, i_rvalid=0, d_rvalid=0.
- Grant (combinational):
  - If starve == STARVE_LIMIT and i_valid: grant = I.
  - Else if d_valid: grant = D.
  - Else if i_valid: grant = I.
  - Else: no grant.
- full = (count == MAX_OUTSTANDING).
- m_valid = (i_valid | d_valid) & !full.
- m_addr/m_wen/m_wdata/m_wmask come from the granted source:
  - Fetch grant: m_wen = 0, m_wdata = 0, m_wmask = 0.
  - No grant: all fields 0.
- i_ready = m_ready & !full & (grant==I); d_ready = m_ready & !full & (grant==D). At most one of them is high in any cycle.
- Issue: on handshake (m_valid & m_ready), push tag {src, addr[2]} at wr_ptr. One issue per cycle maximum.
- Every accepted request, read or write, yields exactly one m_rvalid. Responses return in issue order.
- Response (combinational from FIFO head):
  - i_rvalid = m_rvalid & !empty & head.src==I.
  - d_rvalid = m_rvalid & !empty & head.src==D.
  - d_rdata = m_rdata.
  - i_rdata = head.lane ? m_rdata[63:32] : m_rdata[31:0].
  - Pop the head on m_rvalid & !empty.
- Same-cycle push and pop: count unchanged; both pointers advance and wrap modulo MAX_OUTSTANDING.
- When full, nothing is issued, even if a pop occurs in the same cycle. Issue resumes the next cycle.
- m_rvalid with the FIFO empty: no i_rvalid or d_rvalid is produced, and resp_err is set to 1 and held until rst.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on a D handshake while i_valid = 1.
  - Clears on an I handshake, and in any cycle with i_valid = 0.
- Requesters hold valid and payload stable until ready; the arbiter does not buffer request payloads.
- Reset asserted mid-operation discards all in-flight tags. Responses arriving after reset flag resp_err.

Test Plan:
- Single fetch: i_valid, i_addr=0x8000_0004, m_ready=1, response m_rdata=0x1111_2222_3333_4444 one cycle later -> i_ready=1 in the issue cycle; i_rvalid=1 with i_rdata=0x1111_2222; d_rvalid=0; busy returns to 0.
- Simultaneous request: i_valid & d_valid with d_addr=0x8000_0010, d_wen=1, d_wmask=0xFF -> D granted (m_wen=1, m_addr=0x8000_0010) and i_ready=0. Next cycle, with d_valid low, I is granted. Responses return to d then i, in order.
- Starvation: i_valid held and d_valid held for 10 cycles with m_ready=1 and immediate responses -> D granted 4 times, then I granted on the 5th cycle, then the pattern repeats.
- Backpressure: m_ready=1, no responses, MAX_OUTSTANDING=2 -> two issues, then m_valid=0 and ready=0 while full. The first m_rvalid pops one entry; issue resumes the following cycle.
- Lane select: fetches at 0x...000 then 0x...004, responses 0xAAAA_BBBB_CCCC_DDDD both times -> i_rdata = 0xCCCC_DDDD, then 0xAAAA_BBBB.
- Spurious response and reset: m_rvalid while empty -> resp_err=1, no rvalid to either requester. Then rst mid-flight with 2 tags outstanding -> count=0, busy=0, resp_err=0 on the next cycle.

Source files
------------

// File: rtl/membus_arbiter.sv
// membus_arbiter: shares one MMIO request port between fetch and data buses with in-order response routing
module membus_arbiter #(
  parameter int XLEN            = 64,
  parameter int ILEN            = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [XLEN-1:0]         i_addr,
  output logic                    i_rvalid,
  output logic [ILEN-1:0]         i_rdata,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [XLEN-1:0]         d_addr,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [XLEN-1:0]         m_addr,
  output logic                    m_wen,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wmask,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    busy,
  output logic                    resp_err
);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0] starve;
  logic tag_src [MAX_OUTSTANDING];
  logic tag_lane [MAX_OUTSTANDING];
  logic full, empty, force_i, gnt_i, gnt_d, push, pop;
  assign force_i  = (starve == 4'(STARVE_LIMIT)) & i_valid;
  assign gnt_i    = force_i | (i_valid & !d_valid);
  assign gnt_d    = d_valid & !force_i;
  assign full     = count == CW'(MAX_OUTSTANDING);
  assign empty    = count == '0;
  assign busy     = !empty;
  assign m_valid  = (i_valid | d_valid) & !full;
  assign i_ready  = m_ready & !full & gnt_i;
  assign d_ready  = m_ready & !full & gnt_d;
  assign push     = m_valid & m_ready;
  assign pop      = m_rvalid & !empty;
  assign m_addr   = gnt_d ? d_addr : gnt_i ? i_addr : '0;
  assign m_wen    = gnt_d & d_wen;
  assign m_wdata  = gnt_d ? d_wdata : '0;
  assign m_wmask  = gnt_d ? d_wmask : '0;
  assign i_rvalid = pop & !tag_src[rd_ptr];
  assign d_rvalid = pop & tag_src[rd_ptr];
  assign d_rdata  = m_rdata;
  // fetch words are packed two per beat; the tag remembers which half was asked for
  assign i_rdata  = tag_lane[rd_ptr] ? m_rdata[DATA_WIDTH-1 -: ILEN] : m_rdata[ILEN-1:0];
  always_ff @(posedge clk)
    if (push) begin
      tag_src[wr_ptr]  <= gnt_d;
      tag_lane[wr_ptr] <= m_addr[2];
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      starve   <= '0;
      resp_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
      count    <= count + CW'(push) - CW'(pop);
      resp_err <= resp_err | (m_rvalid & empty);
      starve   <= (i_ready | !i_valid) ? '0 :
                  (d_ready && starve != 4'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
    end
  end
endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter: directed and randomized checks of membus_arbiter against a queue-based model
module tb_membus_arbiter;
  localparam int MO = 2, SL = 4;
  logic clk = 0, rst = 0;
  logic i_valid = 0, i_ready, i_rvalid;
  logic [63:0] i_addr = 0;
  logic [31:0] i_rdata;
  logic d_valid = 0, d_ready, d_wen = 0, d_rvalid;
  logic [63:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic [7:0] d_wmask = 0, m_wmask;
  logic m_valid, m_ready = 0, m_wen, m_rvalid = 0, busy, resp_err;
  logic [63:0] m_addr, m_wdata, m_rdata = 0;
  int n_tests = 0, n_fail = 0;

  membus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_d; bit lane; } tag_t;
  tag_t tagq[$];
  int starve = 0;
  bit err = 0;
  bit e_m_valid, e_i_ready, e_d_ready, e_m_wen, e_i_rvalid, e_d_rvalid, e_busy, g_i, g_d;
  logic [63:0] e_m_addr, e_m_wdata;
  logic [7:0] e_m_wmask;
  logic [31:0] e_i_rdata;

  task automatic model_eval();
    bit full = tagq.size() >= MO;
    g_i = i_valid && (starve == SL || !d_valid);
    g_d = d_valid && !(starve == SL && i_valid);
    e_m_valid = (i_valid || d_valid) && !full;
    e_i_ready = m_ready && !full && g_i;
    e_d_ready = m_ready && !full && g_d;
    e_m_addr  = g_d ? d_addr : g_i ? i_addr : 64'd0;
    e_m_wen   = g_d && d_wen;
    e_m_wdata = g_d ? d_wdata : 64'd0;
    e_m_wmask = g_d ? d_wmask : 8'd0;
    e_i_rvalid = m_rvalid && tagq.size() > 0 && !tagq[0].is_d;
    e_d_rvalid = m_rvalid && tagq.size() > 0 && tagq[0].is_d;
    e_i_rdata  = (tagq.size() > 0 && tagq[0].lane) ? m_rdata[63:32] : m_rdata[31:0];
    e_busy = tagq.size() > 0;
  endtask

  task automatic model_clock();
    model_eval();
    if (rst) begin
      tagq.delete(); starve = 0; err = 0;
    end else begin
      if (m_rvalid && tagq.size() == 0) err = 1;
      if (m_rvalid && tagq.size() > 0) void'(tagq.pop_front());
      if (e_i_ready || e_d_ready) tagq.push_back('{is_d: g_d, lane: g_d ? d_addr[2] : i_addr[2]});
      if (e_i_ready || !i_valid) starve = 0;
      else if (e_d_ready && starve < SL) starve++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0; #1;
    n_tests++; if (busy !== 0 || resp_err !== 0 || m_valid !== 0) begin n_fail++;
      $display("FAIL reset: busy=%b resp_err=%b m_valid=%b required 0 0 0", busy, resp_err, m_valid); end
    n_tests++; if (i_rvalid !== 0 || d_rvalid !== 0) begin n_fail++;
      $display("FAIL reset_rvalid: i_rvalid=%b d_rvalid=%b required 0 0", i_rvalid, d_rvalid); end
  endtask

  task automatic test_single_fetch();
    i_valid = 1; i_addr = 64'h8000_0004; m_ready = 1; #1;
    n_tests++; if (i_ready !== 1 || d_ready !== 0 || m_addr !== 64'h8000_0004 || m_wen !== 0) begin n_fail++;
      $display("FAIL single_issue: i_ready=%b d_ready=%b m_addr=%h m_wen=%b required 1 0 80000004 0", i_ready, d_ready, m_addr, m_wen); end
    tick();
    i_valid = 0; m_rvalid = 1; m_rdata = 64'h1111_2222_3333_4444; #1;
    n_tests++; if (i_rvalid !== 1 || i_rdata !== 32'h1111_2222 || d_rvalid !== 0) begin n_fail++;
      $display("FAIL single_resp: i_rvalid=%b i_rdata=%h d_rvalid=%b required 1 11112222 0", i_rvalid, i_rdata, d_rvalid); end
    tick(); m_rvalid = 0; #1;
    n_tests++; if (busy !== 0) begin n_fail++; $display("FAIL single_busy: busy=%b required 0", busy); end
  endtask

  task automatic test_simultaneous();
    i_valid = 1; i_addr = 64'h8000_0020; d_valid = 1; d_addr = 64'h8000_0010; d_wen = 1;
    d_wmask = 8'hFF; d_wdata = 64'hDEAD_BEEF_0123_4567; m_ready = 1; #1;
    n_tests++; if (d_ready !== 1 || i_ready !== 0 || m_wen !== 1 || m_addr !== 64'h8000_0010 || m_wmask !== 8'hFF) begin n_fail++;
      $display("FAIL simul_d: d_ready=%b i_ready=%b m_wen=%b m_addr=%h m_wmask=%h required 1 0 1 80000010 ff", d_ready, i_ready, m_wen, m_addr, m_wmask); end
    tick(); d_valid = 0; d_wen = 0; #1;
    n_tests++; if (i_ready !== 1 || m_wen !== 0 || m_wdata !== 0 || m_addr !== 64'h8000_0020) begin n_fail++;
      $display("FAIL simul_i: i_ready=%b m_wen=%b m_wdata=%h m_addr=%h required 1 0 0 80000020", i_ready, m_wen, m_wdata, m_addr); end
    tick(); i_valid = 0; m_rvalid = 1; m_rdata = 64'h5555_6666_7777_8888; #1;
    n_tests++; if (d_rvalid !== 1 || i_rvalid !== 0 || d_rdata !== 64'h5555_6666_7777_8888) begin n_fail++;
      $display("FAIL simul_resp_d: d_rvalid=%b i_rvalid=%b d_rdata=%h required 1 0 5555666677778888", d_rvalid, i_rvalid, d_rdata); end
    tick(); #1;
    n_tests++; if (i_rvalid !== 1 || d_rvalid !== 0 || i_rdata !== 32'h7777_8888) begin n_fail++;
      $display("FAIL simul_resp_i: i_rvalid=%b d_rvalid=%b i_rdata=%h required 1 0 77778888", i_rvalid, d_rvalid, i_rdata); end
    tick(); m_rvalid = 0;
  endtask

  task automatic test_starvation();
    string seen = "", want = "DDDDIDDDDI";
    i_valid = 1; i_addr = 64'h8000_1000; d_valid = 1; d_addr = 64'h8000_2000; m_ready = 1;
    for (int c = 0; c < 10; c++) begin
      m_rvalid = tagq.size() > 0; #1;
      seen = {seen, i_ready ? "I" : d_ready ? "D" : "-"};
      tick();
    end
    n_tests++; if (seen != want) begin n_fail++; $display("FAIL starvation: grants=%s required %s", seen, want); end
    i_valid = 0; d_valid = 0; m_rvalid = tagq.size() > 0; tick(); m_rvalid = 0; #1;
    n_tests++; if (busy !== 0) begin n_fail++; $display("FAIL starve_drain: busy=%b required 0", busy); end
  endtask

  task automatic test_backpressure();
    i_valid = 1; i_addr = 64'h8000_0000; m_ready = 1; m_rvalid = 0;
    tick(); tick(); #1;
    n_tests++; if (m_valid !== 0 || i_ready !== 0 || busy !== 1) begin n_fail++;
      $display("FAIL bp_full: m_valid=%b i_ready=%b busy=%b required 0 0 1", m_valid, i_ready, busy); end
    m_rvalid = 1; m_rdata = 64'h0; #1;
    n_tests++; if (m_valid !== 0 || i_ready !== 0 || i_rvalid !== 1) begin n_fail++;
      $display("FAIL bp_pop_no_issue: m_valid=%b i_ready=%b i_rvalid=%b required 0 0 1", m_valid, i_ready, i_rvalid); end
    tick(); m_rvalid = 0; #1;
    n_tests++; if (m_valid !== 1 || i_ready !== 1) begin n_fail++;
      $display("FAIL bp_resume: m_valid=%b i_ready=%b required 1 1", m_valid, i_ready); end
    tick(); i_valid = 0; m_rvalid = 1; tick(); tick(); m_rvalid = 0; #1;
    n_tests++; if (busy !== 0) begin n_fail++; $display("FAIL bp_drain: busy=%b required 0", busy); end
  endtask

  task automatic test_lane();
    m_ready = 1; i_valid = 1; i_addr = 64'h8000_0000; tick();
    i_addr = 64'h8000_0004; m_rvalid = 1; m_rdata = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    n_tests++; if (i_rvalid !== 1 || i_rdata !== 32'hCCCC_DDDD) begin n_fail++;
      $display("FAIL lane_lo: i_rvalid=%b i_rdata=%h required 1 ccccdddd", i_rvalid, i_rdata); end
    tick(); i_valid = 0; #1;
    n_tests++; if (i_rvalid !== 1 || i_rdata !== 32'hAAAA_BBBB) begin n_fail++;
      $display("FAIL lane_hi: i_rvalid=%b i_rdata=%h required 1 aaaabbbb", i_rvalid, i_rdata); end
    tick(); m_rvalid = 0;
  endtask

  task automatic test_spurious_reset();
    m_rvalid = 1; m_rdata = 64'h1234; #1;
    n_tests++; if (i_rvalid !== 0 || d_rvalid !== 0) begin n_fail++;
      $display("FAIL spurious_rvalid: i_rvalid=%b d_rvalid=%b required 0 0", i_rvalid, d_rvalid); end
    tick(); m_rvalid = 0; #1;
    n_tests++; if (resp_err !== 1) begin n_fail++; $display("FAIL spurious_err: resp_err=%b required 1", resp_err); end
    i_valid = 1; d_valid = 1; m_ready = 1; tick(); tick(); i_valid = 0; d_valid = 0; #1;
    n_tests++; if (busy !== 1 || resp_err !== 1) begin n_fail++;
      $display("FAIL err_sticky: busy=%b resp_err=%b required 1 1", busy, resp_err); end
    rst = 1; tick(); rst = 0; #1;
    n_tests++; if (busy !== 0 || resp_err !== 0) begin n_fail++;
      $display("FAIL mid_reset: busy=%b resp_err=%b required 0 0", busy, resp_err); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (!i_valid || e_i_ready) begin
        i_valid = ($urandom_range(0, 2) != 0);
        i_addr = {32'h8000_0000, $urandom()} & ~64'h3;
      end
      if (!d_valid || e_d_ready) begin
        d_valid = ($urandom_range(0, 2) != 0);
        d_addr = {32'h9000_0000, $urandom()};
        d_wen = $urandom_range(0, 1); d_wdata = {$urandom(), $urandom()}; d_wmask = 8'($urandom());
      end
      m_ready = ($urandom_range(0, 3) != 0);
      m_rvalid = tagq.size() > 0 && $urandom_range(0, 2) != 0;
      m_rdata = {$urandom(), $urandom()};
      #1; model_eval();
      n_tests++; if (m_valid !== e_m_valid || i_ready !== e_i_ready || d_ready !== e_d_ready) begin n_fail++;
        $display("FAIL rand_hs c=%0d: m_valid=%b i_ready=%b d_ready=%b required %b %b %b", c, m_valid, i_ready, d_ready, e_m_valid, e_i_ready, e_d_ready); end
      n_tests++; if (m_addr !== e_m_addr || m_wen !== e_m_wen || m_wdata !== e_m_wdata || m_wmask !== e_m_wmask) begin n_fail++;
        $display("FAIL rand_payload c=%0d: addr=%h wen=%b wdata=%h wmask=%h required %h %b %h %h", c, m_addr, m_wen, m_wdata, m_wmask, e_m_addr, e_m_wen, e_m_wdata, e_m_wmask); end
      n_tests++; if (i_rvalid !== e_i_rvalid || d_rvalid !== e_d_rvalid || busy !== e_busy || resp_err !== err) begin n_fail++;
        $display("FAIL rand_resp c=%0d: i_rvalid=%b d_rvalid=%b busy=%b resp_err=%b required %b %b %b %b", c, i_rvalid, d_rvalid, busy, resp_err, e_i_rvalid, e_d_rvalid, e_busy, err); end
      if (e_i_rvalid) begin
        n_tests++; if (i_rdata !== e_i_rdata) begin n_fail++;
          $display("FAIL rand_idata c=%0d: i_rdata=%h required %h", c, i_rdata, e_i_rdata); end
      end
      if (e_d_rvalid) begin
        n_tests++; if (d_rdata !== m_rdata) begin n_fail++;
          $display("FAIL rand_ddata c=%0d: d_rdata=%h required %h", c, d_rdata, m_rdata); end
      end
      tick();
    end
  endtask

  initial begin
    @(negedge clk); #1;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_lane();
    test_spurious_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
